// File: rtl/riscv_uart_pkg.sv
// riscv_uart_pkg: shared FSM encoding and line-level constants for the UART transmitter
package riscv_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;
endpackage

// File: rtl/riscv_sync_fifo.sv
// riscv_sync_fifo: single-clock FIFO with registered occupancy count
// Ports: i_riscv_lsu_clk/i_riscv_lsu_rst clock and async active-high reset; push/wr_data write side
// (ignored while full); pop (ignored while empty); rd_data shows the head entry; full/empty status.
module riscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_riscv_lsu_clk,
    input  logic             i_riscv_lsu_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge i_riscv_lsu_clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/riscv_uart_tx.sv
// riscv_uart_tx: buffered 8N1 UART transmitter fed by LSU stores
// Ports: i_riscv_lsu_clk/i_riscv_lsu_rst clock and async active-high reset; i_riscv_uart_globstall blocks writes;
// i_riscv_uart_tx_valid/i_riscv_uart_tx_data store byte; o_riscv_uart_tx_stall holds the LSU while full;
// o_riscv_uart_tx_full/empty buffer status; o_riscv_uart_tx_busy frame in progress; o_riscv_uart_tx_serial line.
module riscv_uart_tx
    import riscv_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       i_riscv_lsu_clk,
    input  logic       i_riscv_lsu_rst,
    input  logic       i_riscv_uart_globstall,
    input  logic       i_riscv_uart_tx_valid,
    input  logic [7:0] i_riscv_uart_tx_data,
    output logic       o_riscv_uart_tx_stall,
    output logic       o_riscv_uart_tx_full,
    output logic       o_riscv_uart_tx_empty,
    output logic       o_riscv_uart_tx_busy,
    output logic       o_riscv_uart_tx_serial
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    uart_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n, head;
    logic          pop, wrap, serial_n;
    riscv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_riscv_lsu_clk(i_riscv_lsu_clk),
        .i_riscv_lsu_rst(i_riscv_lsu_rst),
        .push(i_riscv_uart_tx_valid && !i_riscv_uart_globstall),
        .wr_data(i_riscv_uart_tx_data),
        .pop(pop),
        .rd_data(head),
        .full(o_riscv_uart_tx_full),
        .empty(o_riscv_uart_tx_empty)
    );
    assign o_riscv_uart_tx_stall = i_riscv_uart_tx_valid && o_riscv_uart_tx_full;
    assign o_riscv_uart_tx_busy  = state != IDLE;
    assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_n = state;
        idx_n   = idx;
        sh_n    = sh;
        pop     = 1'b0;
        cnt_n   = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
        case (state)
            IDLE: if (!o_riscv_uart_tx_empty) begin
                pop     = 1'b1;
                sh_n    = head;
                idx_n   = '0;
                state_n = START;
            end
            START: state_n = wrap ? DATA : START;
            DATA: if (wrap) begin
                sh_n    = sh >> 1;
                idx_n   = idx + 1'b1;
                state_n = (idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
            end
            STOP: state_n = wrap ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        // The line value is computed from the next state so the output flop changes exactly at bit boundaries.
        serial_n = state_n == START ? START_BIT : state_n == DATA ? sh_n[0] : STOP_BIT;
    end
    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            state                  <= IDLE;
            cnt                    <= '0;
            idx                    <= '0;
            sh                     <= '0;
            o_riscv_uart_tx_serial <= STOP_BIT;
        end else begin
            state                  <= state_n;
            cnt                    <= cnt_n;
            idx                    <= idx_n;
            sh                     <= sh_n;
            o_riscv_uart_tx_serial <= serial_n;
        end
    end
endmodule

// File: tb/tb_riscv_uart_tx.sv
// tb_riscv_uart_tx: self-checking bench for riscv_uart_tx against a frame-level reference model
module tb_riscv_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    logic clk = 1'b0, rst = 1'b1, gs = 1'b0, valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic stall, full, empty, busy, serial, last_stall;
    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] q[$];
    bit act;
    int t;
    logic [7:0] cur;
    int bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int busy_cnt, frames, gap, seen, prev_busy, released, busy_seen;
    typedef struct {
        logic       v;
        logic       g;
        logic [7:0] d;
        logic       e_empty;
        logic       e_busy;
        logic       e_serial;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    riscv_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_riscv_lsu_clk(clk),
        .i_riscv_lsu_rst(rst),
        .i_riscv_uart_globstall(gs),
        .i_riscv_uart_tx_valid(valid),
        .i_riscv_uart_tx_data(data),
        .o_riscv_uart_tx_stall(stall),
        .o_riscv_uart_tx_full(full),
        .o_riscv_uart_tx_empty(empty),
        .o_riscv_uart_tx_busy(busy),
        .o_riscv_uart_tx_serial(serial)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // A frame is 10 bit slots of CPB cycles: start, 8 data bits LSB first, stop.
    function automatic logic m_serial();
        if (!act) return 1'b1;
        if (t < CPB) return 1'b0;
        if (t < 9 * CPB) return cur[(t / CPB) - 1];
        return 1'b1;
    endfunction

    task automatic m_reset();
        q.delete();
        act = 0;
        t = 0;
    endtask

    task automatic step(input logic v, input logic g, input logic [7:0] d);
        bit pre_full;
        @(negedge clk);
        valid = v;
        gs = g;
        data = d;
        #1;
        last_stall = stall;
        chk("stall", stall, v && q.size() == DEPTH);
        @(posedge clk);
        pre_full = q.size() == DEPTH;
        if (act) begin
            t++;
            if (t == 10 * CPB) act = 0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
            act = 1;
            t = 0;
        end
        if (v && !g && !pre_full) q.push_back(d);
        cyc++;
        #1;
        chk("serial", serial, m_serial());
        chk("busy", busy, act);
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid = 1'b1;
        gs = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk("rst_serial", serial, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].g, tbl[i].d);
            chk("tbl_empty", empty, tbl[i].e_empty);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_serial", serial, tbl[i].e_serial);
        end
        for (int i = 0; i < 45; i++) step(1'b0, 1'b0, 8'h00);

        do_reset();
        step(1'b1, 1'b0, 8'hA5);
        busy_cnt = 0;
        for (int k = 1; k <= 44; k++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("a5_serial", serial, k <= 4 ? 0 : k <= 36 ? bits[(k - 5) / 4] : 1);
            busy_cnt += int'(busy);
        end
        chk("a5_busy_cycles", busy_cnt, 40);

        do_reset();
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        frames = 0; gap = 0; seen = 0; prev_busy = 1;
        for (int k = 0; k < 130; k++) begin
            step(1'b0, 1'b0, 8'h00);
            if (busy && !prev_busy) begin
                frames++;
                if (seen != 0) chk("frame_gap", gap, 1);
                if (frames == 2) chk("empty_after_third_pop", empty, 1);
                gap = 0;
            end
            if (!busy && prev_busy != 0) seen = 1;
            if (!busy && seen != 0) gap++;
            prev_busy = int'(busy);
        end
        chk("three_frames", frames + 1, 3);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
        chk("full_after_5", full, 1);
        released = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b0, 8'h66);
            if (!full) begin
                chk("drop_on_pop_busy", busy, 1);
                chk("drop_on_pop_stall", last_stall, 1);
                released = 1;
                break;
            end
        end
        chk("full_release_seen", released, 1);
        step(1'b1, 1'b0, 8'h66);
        chk("refill_full", full, 1);
        for (int k = 0; k < 220; k++) step(1'b0, 1'b0, 8'h00);

        do_reset();
        step(1'b1, 1'b0, 8'hC3);
        step(1'b1, 1'b0, 8'h3C);
        step(1'b1, 1'b0, 8'h99);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 8'h00);
        chk("pre_reset_busy", busy, 1);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("async_rst_serial", serial, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_full", full, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 1'b0, 8'h00);
            busy_seen |= int'(busy);
        end
        chk("no_frame_after_reset", busy_seen, 0);

        do_reset();
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
        for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
